// File: rtl/random_range_generator.sv
// Purpose: free-running XNOR Fibonacci LFSR with ranged draws by rejection sampling, bounded retries and a fallback value.
// Latency: valid rises 2..MAX_TRIES+1 edges after the edge that samples req in IDLE.
// Backpressure: the result is held in HOLD with valid=1 until ack; req is ignored outside IDLE. Optional macro: ENTROPY_MIX_EN.
module random_range_generator #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] SEED      = '0,
    parameter logic [WIDTH-1:0] MIN_VAL   = 8'd1,
    parameter logic [WIDTH-1:0] MAX_VAL   = 8'd255,
    parameter int               MAX_TRIES = 16,
    parameter logic [WIDTH-1:0] FALLBACK  = 8'd17
) (
    input  logic             clk,
    input  logic             reset_n,       // active-high despite the name
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             entropy_in,
    input  logic             req,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] value,
    output logic             fallback_used,
    output logic [WIDTH-1:0] rand_raw
);

    localparam int             TW       = $clog2(MAX_TRIES) + 1;
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] tries;
    logic          fb;
    logic          in_range;

`ifndef ENTROPY_MIX_EN
    // entropy_in has no function in the deterministic build
    logic unused_entropy;
    assign unused_entropy = entropy_in;
`endif

    // Feedback bit: XNOR of tapped bits, optionally perturbed by user entropy
    always_comb begin
        fb = ~^(rand_raw & TAPS);
`ifdef ENTROPY_MIX_EN
        fb = fb ^ entropy_in;
`endif
    end

    // Candidate range test; one extra bit keeps the bounds from being trivially constant at full width
    always_comb begin
        in_range = ({1'b0, rand_raw} >= {1'b0, MIN_VAL}) && ({1'b0, rand_raw} <= {1'b0, MAX_VAL});
    end

    // LFSR: seed load wins over advance; an all-ones seed would lock the XNOR LFSR so it becomes zero
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            rand_raw <= SEED;
        end else if (seed_load) begin
            rand_raw <= (&seed_in) ? '0 : seed_in;
        end else if (enable || state == DRAW) begin
            rand_raw <= {rand_raw[WIDTH-2:0], fb};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; ack only counts once valid is visible to the consumer
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req) next_state = DRAW;
            DRAW: if (in_range || tries == LAST_TRY) next_state = HOLD;
            HOLD: if (ack && valid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Draw datapath: try counter, captured value and fallback flag
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            tries         <= '0;
            value         <= '0;
            fallback_used <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) tries <= '0;
                end
                DRAW: begin
                    if (in_range) begin
                        value         <= rand_raw;
                        fallback_used <= 1'b0;
                    end else if (tries == LAST_TRY) begin
                        value         <= FALLBACK;
                        fallback_used <= 1'b1;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status: busy tracks DRAW, valid follows entry into HOLD by one edge and drops on the ack edge
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            busy  <= (next_state == DRAW);
            valid <= (state == HOLD) && (next_state == HOLD);
        end
    end

endmodule

// File: doc/random_range_generator.md
Name: random_range_generator

Overview:
- Parametrised successor to the game's 8-bit LFSR plus store-register random state source.
- A configurable-width XNOR Fibonacci LFSR runs continuously. On request, it draws values by rejection sampling until one falls in [MIN_VAL, MAX_VAL], with a bounded retry count and a fallback value.
- The result is held under a valid/ack handshake.
- Used by the game controller to obtain a legal initial game state, or any ranged random value, without a zero or out-of-range start.

Parameters:
- WIDTH, 8: LFSR and value width in bits (3..32).
- TAPS, 8'hB8: tap mask, WIDTH bits. Feedback = XNOR-reduce(lfsr & TAPS).
- SEED, 0: LFSR reset value. Must not be all-ones.
- MIN_VAL, 1: inclusive lower bound, unsigned.
- MAX_VAL, 255: inclusive upper bound, unsigned. Must satisfy MIN_VAL <= MAX_VAL <= 2^WIDTH-1.
- MAX_TRIES, 16: draw attempts before fallback (>=1).
- FALLBACK, 17: value returned when retries are exhausted. Must lie in range.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-high reset (the port name is historical; high = reset).
- enable  in  1  free-run advance of the LFSR while not drawing.
- seed_load  in  1  single-cycle load of seed_in into the LFSR.
- seed_in  in  WIDTH  seed value.
- entropy_in  in  1  user entropy bit; used only when ENTROPY_MIX_EN is defined.
- req  in  1  draw request, sampled in IDLE only.
- ack  in  1  consumer accepts value, honoured in HOLD only.
- busy  out  1  high in DRAW.
- valid  out  1  high in HOLD.
- value  out  WIDTH  accepted or fallback value.
- fallback_used  out  1  value came from FALLBACK. Valid while valid=1.
- rand_raw  out  WIDTH  current LFSR state (debug/observation).

Behaviour:
- Reset (asynchronous, immediate, including mid-DRAW or mid-HOLD):
  - state=IDLE, LFSR=SEED, try counter=0.
  - busy=0, valid=0, value=0, fallback_used=0.
- LFSR update: next = {lfsr[WIDTH-2:0], fb}.
- Advance condition: advances on every edge where (enable=1 or state=DRAW) and seed_load=0.
- seed_load=1 has priority over advance. The LFSR loads seed_in. If seed_in is all-ones (XNOR lockup), it loads 0 instead.
- FSM states: IDLE, DRAW, HOLD (2-bit register).
- IDLE:
  - On req=1 at an edge: go to DRAW and clear the try counter.
  - Otherwise stay. ack is ignored.
- DRAW:
  - Each edge, candidate = rand_raw as it was before that edge. The comparison is unsigned, full WIDTH.
  - If MIN_VAL <= candidate <= MAX_VAL: value<=candidate, fallback_used<=0, go to HOLD.
  - Else if the try counter = MAX_TRIES-1: value<=FALLBACK, fallback_used<=1, go to HOLD.
  - Else: increment the try counter and stay.
  - req and ack are ignored. seed_load in DRAW does not affect the candidate sampled on that edge.
- HOLD:
  - valid=1. value and fallback_used stay stable until ack.
  - On ack=1: go to IDLE, valid drops after that edge.
  - req is ignored in HOLD, including when req=ack=1 on the same edge. A new draw needs req in IDLE.
- Latency:
  - Minimum: valid rises 2 edges after the req-sampling edge.
  - Maximum: MAX_TRIES+1 edges.
- Try counter width: clog2(MAX_TRIES)+1. No wrap.
- valid and busy are registered and never high simultaneously.

Optional Feature:
- Macro: ENTROPY_MIX_EN.
- When defined: fb = XNOR-reduce(lfsr & TAPS) XOR entropy_in. The LFSR is no longer a pure sequence; all-ones may be reached and is permitted.
- When undefined: entropy_in is unconnected and ignored, and the sequence is deterministic from SEED/seed_in.

Test Plan:
- Defaults. Release reset, enable=1, 4 edges -> rand_raw = 0x01, 0x03, 0x07, 0x0F.
- Defaults, enable=0, req pulse at edge k:
  - k+1: candidate 0x00 rejected.
  - k+2: candidate 0x01 accepted.
  - Result: valid=1, value=0x01, fallback_used=0.
- MIN_VAL=MAX_VAL=200, FALLBACK=200, MAX_TRIES=4, enable=0, req:
  - Candidates 0x00, 0x01, 0x03, 0x07 are rejected.
  - Result: value=200, fallback_used=1, valid at req edge+5.
- In HOLD, ack=0 for 10 cycles with req=1 -> value and valid stable. Then ack=1 -> valid=0 and state IDLE on the next edge, with no new draw started.
- seed_load with seed_in=0xFF -> rand_raw=0x00. seed_load with 0x5A, enable=1 -> rand_raw 0x5A, then 0xB5.
- Assert reset mid-DRAW (asynchronously, between edges) -> busy=0, valid=0, value=0, rand_raw=SEED immediately. With ENTROPY_MIX_EN, entropy_in=1, one enable edge from reset -> rand_raw=0x00.
